// File: rtl/hsi_pkg.sv
// Shared definitions for the payload path: arbiter state encoding, on/off levels and
// an index helper.
package hsi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam int unsigned IDX_W = 3;

    // Increment a source index, wrapping to zero at n.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                  input int unsigned n);
        if (32'(idx) + 32'd1 >= n) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, with wrap.
module rr_pick
    import hsi_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    int unsigned cand;

    always_comb begin
        valid = OFF;
        idx   = '0;
        cand  = 0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            cand = 32'(ptr) + 32'(off);
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            for (int j = 0; j < NUM_SRC; j++) begin
                if (req[j] && (cand == 32'(j))) begin
                    valid = ON;
                    idx   = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/payload_arbiter.sv
// Round-robin arbiter sharing one line coder among NUM_SRC payload generators, with a
// launch-acknowledge timeout that drops a stalled transfer.
module payload_arbiter
    import hsi_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clk_en,
    input  logic [NUM_SRC-1:0]   src_rdy,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_busy,
    input  logic                 cd_busy,
    output logic                 cd_start,
    output logic [7:0]           cd_data,
    output logic [2:0]           grant_id,
    output logic                 err_timeout
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_SRC-1:0] busy_q, busy_d;
    logic               start_q, start_d;
    logic [7:0]         data_q, data_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ack_expired;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [7:0]         pick_byte;
    logic [NUM_SRC-1:0] pick_onehot;

    rr_pick #(
        .NUM_SRC(NUM_SRC)
    ) u_rr_pick (
        .req  (src_rdy),
        .ptr  (rr_ptr_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    always_comb begin
        pick_byte   = '0;
        pick_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_byte      = src_data[8*i +: 8];
                pick_onehot[i] = ON;
            end
        end
    end

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign ack_expired = (cnt_inc == CNT_W'(ACK_TIMEOUT));

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (pick_valid) state_d = ST_LAUNCH;
            ST_LAUNCH:    state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (cd_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: if (!cd_busy) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Registered-output next values; pulses default low and are held while clk_en is 0
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        busy_d   = busy_q;
        start_d  = OFF;
        data_d   = data_q;
        grant_d  = grant_q;
        err_d    = OFF;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    data_d  = pick_byte;
                    grant_d = pick_idx;
                    busy_d  = pick_onehot;
                    start_d = ON;
                end
            end
            ST_LAUNCH: cnt_d = '0;
            ST_WAIT_ACK: begin
                if (!cd_busy) begin
                    cnt_d = cnt_inc;
                    if (ack_expired) begin
                        err_d    = ON;
                        busy_d   = '0;
                        rr_ptr_d = wrap_inc(grant_q, NUM_SRC);
                        cnt_d    = '0;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!cd_busy) begin
                    busy_d   = '0;
                    rr_ptr_d = wrap_inc(grant_q, NUM_SRC);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rr_ptr_q <= '0;
            busy_q   <= '0;
            start_q  <= OFF;
            data_q   <= 8'h00;
            grant_q  <= '0;
            err_q    <= OFF;
            cnt_q    <= '0;
        end else if (clk_en) begin
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            data_q   <= data_d;
            grant_q  <= grant_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign src_busy    = busy_q;
    assign cd_start    = start_q;
    assign cd_data     = data_q;
    assign grant_id    = grant_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_payload_arbiter.sv
// Directed self-checking bench for payload_arbiter with NUM_SRC=4, ACK_TIMEOUT=15.
module tb_payload_arbiter;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        clk_en;
    logic [3:0]  src_rdy;
    logic [31:0] src_data;
    logic [3:0]  src_busy;
    logic        cd_busy;
    logic        cd_start;
    logic [7:0]  cd_data;
    logic [2:0]  grant_id;
    logic        err_timeout;

    int tests = 0;
    int fails = 0;

    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h5A, 8'h44};

    payload_arbiter #(
        .NUM_SRC    (4),
        .ACK_TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clk_en     (clk_en),
        .src_rdy    (src_rdy),
        .src_data   (src_data),
        .src_busy   (src_busy),
        .cd_busy    (cd_busy),
        .cd_start   (cd_start),
        .cd_data    (cd_data),
        .grant_id   (grant_id),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(src_busy), 32'h0);
        chk({tag, "_start"}, 32'(cd_start), 32'h0);
        chk({tag, "_data"}, 32'(cd_data), 32'h0);
        chk({tag, "_grant"}, 32'(grant_id), 32'h0);
        chk({tag, "_err"}, 32'(err_timeout), 32'h0);
    endtask

    // One full transfer from IDLE with a one-cycle coder busy; sources stay ready.
    task automatic serve(input logic [2:0] id);
        tick(1);
        chk("rr_grant", 32'(grant_id), 32'(id));
        chk("rr_data", 32'(cd_data), 32'(bytes[id]));
        chk("rr_start", 32'(cd_start), 32'h1);
        chk("rr_busy", 32'(src_busy), 32'(4'(1) << id));
        tick(1);
        cd_busy = 1'b1;
        tick(1);
        cd_busy = 1'b0;
        tick(1);
        chk("rr_busy_clr", 32'(src_busy), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_rst    = 1'b0;
        clk_en   = 1'b1;
        src_rdy  = 4'b0000;
        src_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
        cd_busy  = 1'b0;
        tick(2);
        chk_reset_vals("reset");
        n_rst = 1'b1;
        tick(1);

        // Single source 2, coder busy for 3 cycles, source drops ready after grant
        src_rdy = 4'b0100;
        tick(1);
        chk("single_busy", 32'(src_busy), 32'h4);
        chk("single_start", 32'(cd_start), 32'h1);
        chk("single_data", 32'(cd_data), 32'h5A);
        chk("single_grant", 32'(grant_id), 32'h2);
        src_rdy = 4'b0000;
        tick(1);
        chk("single_start_off", 32'(cd_start), 32'h0);
        cd_busy = 1'b1;
        tick(3);
        cd_busy = 1'b0;
        chk("single_busy_held", 32'(src_busy), 32'h4);
        tick(1);
        chk("single_busy_clr", 32'(src_busy), 32'h0);
        chk("single_err", 32'(err_timeout), 32'h0);
        chk("single_data_kept", 32'(cd_data), 32'h5A);

        // rr_ptr is now 3; grant source 1 by wrap, then reset during WAIT_DONE
        src_rdy = 4'b0010;
        tick(1);
        chk("rst_pre_grant", 32'(grant_id), 32'h1);
        src_rdy = 4'b0000;
        tick(1);
        cd_busy = 1'b1;
        tick(1);
        chk("rst_pre_busy", 32'(src_busy), 32'h2);
        #2;
        n_rst = 1'b0;
        #1;
        chk_reset_vals("rst_async");
        cd_busy = 1'b0;
        tick(1);
        chk("rst_no_err", 32'(err_timeout), 32'h0);
        n_rst = 1'b1;

        // All four ready from a freshly reset pointer
        src_rdy = 4'b1111;
        serve(3'd0);
        serve(3'd1);
        serve(3'd2);
        serve(3'd3);
        serve(3'd0);
        src_rdy = 4'b0000;
        tick(1);

        // Timeout: rr_ptr=1, only source 0 ready, coder never answers
        src_rdy = 4'b0001;
        tick(1);
        chk("to_grant", 32'(grant_id), 32'h0);
        src_rdy = 4'b0000;
        tick(1);
        tick(14);
        chk("to_err_early", 32'(err_timeout), 32'h0);
        chk("to_busy_early", 32'(src_busy), 32'h1);
        tick(1);
        chk("to_err", 32'(err_timeout), 32'h1);
        chk("to_busy_clr", 32'(src_busy), 32'h0);
        src_rdy = 4'b0011;
        tick(1);
        chk("to_err_pulse", 32'(err_timeout), 32'h0);
        chk("to_next_grant", 32'(grant_id), 32'h1);
        src_rdy = 4'b0000;
        tick(1);
        tick(14);
        cd_busy = 1'b1;
        tick(1);
        chk("ack15_err", 32'(err_timeout), 32'h0);
        chk("ack15_busy", 32'(src_busy), 32'h2);
        cd_busy = 1'b0;
        tick(1);
        chk("ack15_done", 32'(src_busy), 32'h0);
        chk("ack15_err2", 32'(err_timeout), 32'h0);

        // clk_en gaps in each state; rr_ptr=2
        src_rdy = 4'b0100;
        clk_en  = 1'b0;
        tick(1);
        chk("en_idle_busy", 32'(src_busy), 32'h0);
        chk("en_idle_start", 32'(cd_start), 32'h0);
        clk_en = 1'b1;
        tick(1);
        chk("en_launch_start", 32'(cd_start), 32'h1);
        chk("en_launch_busy", 32'(src_busy), 32'h4);
        src_rdy = 4'b0000;
        clk_en  = 1'b0;
        tick(2);
        chk("en_start_held", 32'(cd_start), 32'h1);
        clk_en = 1'b1;
        tick(1);
        chk("en_start_once", 32'(cd_start), 32'h0);
        cd_busy = 1'b1;
        clk_en  = 1'b0;
        tick(1);
        clk_en = 1'b1;
        tick(1);
        cd_busy = 1'b0;
        clk_en  = 1'b0;
        tick(1);
        chk("en_done_frozen", 32'(src_busy), 32'h4);
        clk_en = 1'b1;
        tick(1);
        chk("en_done_clr", 32'(src_busy), 32'h0);
        chk("en_start_none", 32'(cd_start), 32'h0);

        // Coder busy high during LAUNCH must be ignored; rr_ptr=3
        src_rdy = 4'b1000;
        tick(1);
        chk("ign_grant", 32'(grant_id), 32'h3);
        chk("ign_data", 32'(cd_data), 32'h44);
        src_rdy = 4'b0000;
        cd_busy = 1'b1;
        tick(1);
        cd_busy = 1'b0;
        tick(2);
        chk("ign_busy_held", 32'(src_busy), 32'h8);
        cd_busy = 1'b1;
        tick(1);
        cd_busy = 1'b0;
        tick(1);
        chk("ign_busy_clr", 32'(src_busy), 32'h0);
        chk("ign_data_kept", 32'(cd_data), 32'h44);
        chk("ign_err", 32'(err_timeout), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
